// File: rtl/vx_warp_ctl_handler.sv
// Warp-control consumer: owns active/stalled warp masks, per-warp thread masks,
// barrier tracking and per-warp IPDOM reconvergence stacks feeding the scheduler.
module vx_warp_ctl_handler #(
    parameter int NUM_WARPS    = 4,
    parameter int NUM_THREADS  = 4,
    parameter int NUM_BARRIERS = 4,
    parameter int IPDOM_DEPTH  = 4,
    localparam int NW_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int NB_BITS = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             ctl_valid,
    input  logic [NW_BITS-1:0]               ctl_wid,
    input  logic                             tmc_valid,
    input  logic [NUM_THREADS-1:0]           tmc_tmask,
    input  logic                             wspawn_valid,
    input  logic [NUM_WARPS-1:0]             wspawn_wmask,
    input  logic [31:0]                      wspawn_pc,
    input  logic                             split_valid,
    input  logic                             split_diverged,
    input  logic [NUM_THREADS-1:0]           split_then_tmask,
    input  logic [NUM_THREADS-1:0]           split_else_tmask,
    input  logic [31:0]                      split_pc,
    input  logic                             barrier_valid,
    input  logic [NB_BITS-1:0]               barrier_id,
    input  logic [NW_BITS-1:0]               barrier_size_m1,
    input  logic                             join_valid,
    input  logic [NW_BITS-1:0]               join_wid,
    output logic                             join_ready,
    output logic [NUM_WARPS-1:0]             active_warps,
    output logic [NUM_WARPS-1:0]             stalled_warps,
    output logic [NUM_WARPS*NUM_THREADS-1:0] thread_masks,
    output logic                             wspawn_out_valid,
    output logic [NUM_WARPS-1:0]             wspawn_out_wmask,
    output logic [31:0]                      wspawn_out_pc,
    output logic                             branch_valid,
    output logic [NW_BITS-1:0]               branch_wid,
    output logic [31:0]                      branch_pc,
    output logic                             ipdom_err
);

    localparam int SP_BITS = $clog2(IPDOM_DEPTH + 1);
    localparam int ID_BITS = (IPDOM_DEPTH > 1) ? $clog2(IPDOM_DEPTH) : 1;

    typedef struct packed {
        logic                   ft;
        logic [NUM_THREADS-1:0] tmask;
        logic [31:0]            pc;
    } ipdom_entry_t;

    logic [NUM_WARPS-1:0]   active_reg, active_next;
    logic [NUM_WARPS-1:0]   stalled_reg, stalled_next;
    logic [NUM_THREADS-1:0] tmask_reg [NUM_WARPS];
    logic [NUM_THREADS-1:0] tmask_next [NUM_WARPS];
    ipdom_entry_t           stack_reg [NUM_WARPS][IPDOM_DEPTH];
    ipdom_entry_t           stack_next [NUM_WARPS][IPDOM_DEPTH];
    logic [SP_BITS-1:0]     sp_reg [NUM_WARPS];
    logic [SP_BITS-1:0]     sp_next [NUM_WARPS];
    logic [NW_BITS-1:0]     bar_cnt_reg [NUM_BARRIERS];
    logic [NW_BITS-1:0]     bar_cnt_next [NUM_BARRIERS];
    logic [NUM_WARPS-1:0]   bar_wait_reg [NUM_BARRIERS];
    logic [NUM_WARPS-1:0]   bar_wait_next [NUM_BARRIERS];

    logic                   wsp_valid_reg, wsp_valid_next;
    logic [NUM_WARPS-1:0]   wsp_mask_reg, wsp_mask_next;
    logic [31:0]            wsp_pc_reg, wsp_pc_next;
    logic                   br_valid_reg, br_valid_next;
    logic [NW_BITS-1:0]     br_wid_reg, br_wid_next;
    logic [31:0]            br_pc_reg, br_pc_next;
    logic                   err_reg, err_next;

    logic [NUM_WARPS-1:0]   spawn_mask;
    logic [ID_BITS-1:0]     wr_idx, wr_idx1, rd_idx;
    ipdom_entry_t           top_entry;

    assign join_ready = !ctl_valid;

    always_comb begin
        active_next    = active_reg;
        stalled_next   = stalled_reg;
        tmask_next     = tmask_reg;
        stack_next     = stack_reg;
        sp_next        = sp_reg;
        bar_cnt_next   = bar_cnt_reg;
        bar_wait_next  = bar_wait_reg;
        wsp_valid_next = 1'b0;
        wsp_mask_next  = '0;
        wsp_pc_next    = '0;
        br_valid_next  = 1'b0;
        br_wid_next    = '0;
        br_pc_next     = '0;
        err_next       = 1'b0;
        spawn_mask     = '0;
        wr_idx         = ID_BITS'(sp_reg[ctl_wid]);
        wr_idx1        = wr_idx + ID_BITS'(1);
        rd_idx         = ID_BITS'(sp_reg[join_wid] - SP_BITS'(1));
        top_entry      = stack_reg[join_wid][rd_idx];

        if (ctl_valid) begin
            if (tmc_valid) begin
                tmask_next[ctl_wid] = tmc_tmask;
                if (tmc_tmask == '0)
                    active_next[ctl_wid] = 1'b0;
            end else if (wspawn_valid) begin
                // The requesting warp is already running; never redirect it.
                spawn_mask = wspawn_wmask & ~(NUM_WARPS'(1) << ctl_wid);
                active_next = active_reg | spawn_mask;
                for (int w = 0; w < NUM_WARPS; w++)
                    if (spawn_mask[w])
                        tmask_next[w] = NUM_THREADS'(1);
                if (spawn_mask != '0) begin
                    wsp_valid_next = 1'b1;
                    wsp_mask_next  = spawn_mask;
                    wsp_pc_next    = wspawn_pc;
                end
            end else if (split_valid) begin
                if (split_diverged) begin
                    if (int'(sp_reg[ctl_wid]) + 2 <= IPDOM_DEPTH) begin
                        stack_next[ctl_wid][wr_idx]  = '{ft: 1'b1, tmask: tmask_reg[ctl_wid], pc: 32'h0};
                        stack_next[ctl_wid][wr_idx1] = '{ft: 1'b0, tmask: split_else_tmask, pc: split_pc};
                        sp_next[ctl_wid]    = sp_reg[ctl_wid] + SP_BITS'(2);
                        tmask_next[ctl_wid] = split_then_tmask;
                    end else begin
                        err_next = 1'b1;
                    end
                end else begin
                    if (int'(sp_reg[ctl_wid]) + 1 <= IPDOM_DEPTH) begin
                        stack_next[ctl_wid][wr_idx] = '{ft: 1'b1, tmask: tmask_reg[ctl_wid], pc: 32'h0};
                        sp_next[ctl_wid] = sp_reg[ctl_wid] + SP_BITS'(1);
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end else if (barrier_valid) begin
                if (bar_cnt_reg[barrier_id] == barrier_size_m1) begin
                    stalled_next = stalled_reg & ~bar_wait_reg[barrier_id];
                    bar_wait_next[barrier_id] = '0;
                    bar_cnt_next[barrier_id]  = '0;
                end else begin
                    bar_cnt_next[barrier_id] = bar_cnt_reg[barrier_id] + NW_BITS'(1);
                    bar_wait_next[barrier_id][ctl_wid] = 1'b1;
                    stalled_next[ctl_wid] = 1'b1;
                end
            end
        end else if (join_valid) begin
            if (sp_reg[join_wid] == '0) begin
                err_next = 1'b1;
            end else begin
                sp_next[join_wid]    = sp_reg[join_wid] - SP_BITS'(1);
                tmask_next[join_wid] = top_entry.tmask;
                if (!top_entry.ft) begin
                    br_valid_next = 1'b1;
                    br_wid_next   = join_wid;
                    br_pc_next    = top_entry.pc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_reg  <= NUM_WARPS'(1);
            stalled_reg <= '0;
            for (int w = 0; w < NUM_WARPS; w++) begin
                tmask_reg[w] <= (w == 0) ? NUM_THREADS'(1) : '0;
                sp_reg[w]    <= '0;
                for (int d = 0; d < IPDOM_DEPTH; d++)
                    stack_reg[w][d] <= '0;
            end
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                bar_cnt_reg[b]  <= '0;
                bar_wait_reg[b] <= '0;
            end
            wsp_valid_reg <= 1'b0;
            wsp_mask_reg  <= '0;
            wsp_pc_reg    <= '0;
            br_valid_reg  <= 1'b0;
            br_wid_reg    <= '0;
            br_pc_reg     <= '0;
            err_reg       <= 1'b0;
        end else begin
            active_reg    <= active_next;
            stalled_reg   <= stalled_next;
            tmask_reg     <= tmask_next;
            sp_reg        <= sp_next;
            stack_reg     <= stack_next;
            bar_cnt_reg   <= bar_cnt_next;
            bar_wait_reg  <= bar_wait_next;
            wsp_valid_reg <= wsp_valid_next;
            wsp_mask_reg  <= wsp_mask_next;
            wsp_pc_reg    <= wsp_pc_next;
            br_valid_reg  <= br_valid_next;
            br_wid_reg    <= br_wid_next;
            br_pc_reg     <= br_pc_next;
            err_reg       <= err_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_tmask_out
            assign thread_masks[gi*NUM_THREADS +: NUM_THREADS] = tmask_reg[gi];
        end
    endgenerate

    assign active_warps     = active_reg;
    assign stalled_warps    = stalled_reg;
    assign wspawn_out_valid = wsp_valid_reg;
    assign wspawn_out_wmask = wsp_mask_reg;
    assign wspawn_out_pc    = wsp_pc_reg;
    assign branch_valid     = br_valid_reg;
    assign branch_wid       = br_wid_reg;
    assign branch_pc        = br_pc_reg;
    assign ipdom_err        = err_reg;

endmodule

// File: tb/tb_vx_warp_ctl_handler.sv
// Self-checking bench for vx_warp_ctl_handler: expected pulse outputs are queued
// as each request is driven and compared when the registered result appears.
module tb_vx_warp_ctl_handler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ctl_valid, tmc_valid, wspawn_valid, split_valid, split_diverged;
    logic        barrier_valid, join_valid, join_ready;
    logic [1:0]  ctl_wid, barrier_id, barrier_size_m1, join_wid, branch_wid;
    logic [3:0]  tmc_tmask, wspawn_wmask, split_then_tmask, split_else_tmask;
    logic [31:0] wspawn_pc, split_pc, wspawn_out_pc, branch_pc;
    logic [3:0]  active_warps, stalled_warps, wspawn_out_wmask;
    logic [15:0] thread_masks;
    logic        wspawn_out_valid, branch_valid, ipdom_err;

    typedef struct packed {
        logic        wv;
        logic [3:0]  wm;
        logic [31:0] wpc;
        logic        bv;
        logic [1:0]  bw;
        logic [31:0] bpc;
        logic        err;
    } pulse_t;

    pulse_t sb[$];
    pulse_t e;
    int checks = 0;
    int errors = 0;

    vx_warp_ctl_handler dut (
        .clk(clk), .reset(reset),
        .ctl_valid(ctl_valid), .ctl_wid(ctl_wid),
        .tmc_valid(tmc_valid), .tmc_tmask(tmc_tmask),
        .wspawn_valid(wspawn_valid), .wspawn_wmask(wspawn_wmask), .wspawn_pc(wspawn_pc),
        .split_valid(split_valid), .split_diverged(split_diverged),
        .split_then_tmask(split_then_tmask), .split_else_tmask(split_else_tmask), .split_pc(split_pc),
        .barrier_valid(barrier_valid), .barrier_id(barrier_id), .barrier_size_m1(barrier_size_m1),
        .join_valid(join_valid), .join_wid(join_wid), .join_ready(join_ready),
        .active_warps(active_warps), .stalled_warps(stalled_warps), .thread_masks(thread_masks),
        .wspawn_out_valid(wspawn_out_valid), .wspawn_out_wmask(wspawn_out_wmask), .wspawn_out_pc(wspawn_out_pc),
        .branch_valid(branch_valid), .branch_wid(branch_wid), .branch_pc(branch_pc),
        .ipdom_err(ipdom_err)
    );

    always #5 clk = ~clk;

    function automatic pulse_t obs();
        return {wspawn_out_valid, wspawn_out_wmask, wspawn_out_pc,
                branch_valid, branch_wid, branch_pc, ipdom_err};
    endfunction

    function automatic pulse_t p_none();
        return '0;
    endfunction

    function automatic pulse_t p_wsp(input logic [3:0] m, input logic [31:0] pc);
        pulse_t p = '0;
        p.wv = 1'b1; p.wm = m; p.wpc = pc;
        return p;
    endfunction

    function automatic pulse_t p_br(input logic [1:0] w, input logic [31:0] pc);
        pulse_t p = '0;
        p.bv = 1'b1; p.bw = w; p.bpc = pc;
        return p;
    endfunction

    function automatic pulse_t p_err();
        pulse_t p = '0;
        p.err = 1'b1;
        return p;
    endfunction

    task automatic clear_inputs();
        ctl_valid = 0; ctl_wid = 0; tmc_valid = 0; tmc_tmask = 0;
        wspawn_valid = 0; wspawn_wmask = 0; wspawn_pc = 0;
        split_valid = 0; split_diverged = 0; split_then_tmask = 0; split_else_tmask = 0; split_pc = 0;
        barrier_valid = 0; barrier_id = 0; barrier_size_m1 = 0;
        join_valid = 0; join_wid = 0;
    endtask

    task automatic edge_then_clear();
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic do_tmc(input logic [1:0] w, input logic [3:0] m);
        @(negedge clk);
        ctl_valid = 1; ctl_wid = w; tmc_valid = 1; tmc_tmask = m;
        edge_then_clear();
    endtask

    task automatic do_wspawn(input logic [1:0] w, input logic [3:0] m, input logic [31:0] pc);
        @(negedge clk);
        ctl_valid = 1; ctl_wid = w; wspawn_valid = 1; wspawn_wmask = m; wspawn_pc = pc;
        edge_then_clear();
    endtask

    task automatic do_split(input logic [1:0] w, input logic div, input logic [3:0] t,
                            input logic [3:0] el, input logic [31:0] pc);
        @(negedge clk);
        ctl_valid = 1; ctl_wid = w; split_valid = 1; split_diverged = div;
        split_then_tmask = t; split_else_tmask = el; split_pc = pc;
        edge_then_clear();
    endtask

    task automatic do_barrier(input logic [1:0] w, input logic [1:0] id, input logic [1:0] sm1);
        @(negedge clk);
        ctl_valid = 1; ctl_wid = w; barrier_valid = 1; barrier_id = id; barrier_size_m1 = sm1;
        edge_then_clear();
    endtask

    task automatic do_join(input logic [1:0] w);
        @(negedge clk);
        join_valid = 1; join_wid = w;
        edge_then_clear();
    endtask

    task automatic test_reset();
        clear_inputs();
        #12;
        checks++;
        if (active_warps !== 4'b0001) begin errors++; $display("FAIL reset_active got=%b want=0001", active_warps); end
        checks++;
        if (thread_masks !== 16'h0001) begin errors++; $display("FAIL reset_tmask got=%h want=0001", thread_masks); end
        checks++;
        if (stalled_warps !== 4'b0000) begin errors++; $display("FAIL reset_stalled got=%b want=0000", stalled_warps); end
        checks++;
        if (obs() !== p_none()) begin errors++; $display("FAIL reset_pulses got=%h want=0", obs()); end
        checks++;
        if (join_ready !== 1'b1) begin errors++; $display("FAIL reset_join_ready got=%b want=1", join_ready); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_wspawn();
        sb.push_back(p_wsp(4'b1110, 32'h80000100));
        do_wspawn(2'd0, 4'b1111, 32'h80000100);
        e = sb.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL wspawn_pulse got=%h want=%h", obs(), e); end
        checks++;
        if (active_warps !== 4'b1111) begin errors++; $display("FAIL wspawn_active got=%b want=1111", active_warps); end
        checks++;
        if (thread_masks !== 16'h1111) begin errors++; $display("FAIL wspawn_tmask got=%h want=1111", thread_masks); end
        // Spawning only the requester itself yields an empty mask: no redirect.
        sb.push_back(p_none());
        do_wspawn(2'd1, 4'b0010, 32'h1234);
        e = sb.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL wspawn_self_pulse got=%h want=%h", obs(), e); end
        sb.push_back(p_none());
        do_tmc(2'd2, 4'b0000);
        e = sb.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL tmc_pulse got=%h want=%h", obs(), e); end
        checks++;
        if (active_warps !== 4'b1011) begin errors++; $display("FAIL tmc_active got=%b want=1011", active_warps); end
        checks++;
        if (thread_masks !== 16'h1011) begin errors++; $display("FAIL tmc_tmask got=%h want=1011", thread_masks); end
    endtask

    task automatic test_split();
        sb.push_back(p_none());
        do_tmc(2'd0, 4'hF);
        e = sb.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL split_tmc_pulse got=%h want=%h", obs(), e); end
        sb.push_back(p_none());
        do_split(2'd0, 1'b1, 4'b0011, 4'b1100, 32'h200);
        e = sb.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL split_pulse got=%h want=%h", obs(), e); end
        checks++;
        if (thread_masks[3:0] !== 4'b0011) begin errors++; $display("FAIL split_then got=%b want=0011", thread_masks[3:0]); end
        sb.push_back(p_br(2'd0, 32'h200));
        do_join(2'd0);
        e = sb.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL join1_pulse got=%h want=%h", obs(), e); end
        checks++;
        if (thread_masks[3:0] !== 4'b1100) begin errors++; $display("FAIL join1_tmask got=%b want=1100", thread_masks[3:0]); end
        sb.push_back(p_none());
        do_join(2'd0);
        e = sb.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL join2_pulse got=%h want=%h", obs(), e); end
        checks++;
        if (thread_masks[3:0] !== 4'hF) begin errors++; $display("FAIL join2_tmask got=%b want=1111", thread_masks[3:0]); end
        // Non-diverged split pushes one fallthrough entry and keeps the mask.
        sb.push_back(p_none());
        do_split(2'd0, 1'b0, 4'b0001, 4'b0000, 32'h220);
        e = sb.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL uniform_split_pulse got=%h want=%h", obs(), e); end
        checks++;
        if (thread_masks[3:0] !== 4'hF) begin errors++; $display("FAIL uniform_split_tmask got=%b want=1111", thread_masks[3:0]); end
        sb.push_back(p_none());
        do_join(2'd0);
        e = sb.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL uniform_join_pulse got=%h want=%h", obs(), e); end
    endtask

    task automatic test_barrier();
        logic [1:0] warps [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [3:0] stall [5] = '{4'b0001, 4'b0011, 4'b0000, 4'b1000, 4'b1001};
        for (int i = 0; i < 5; i++) begin
            sb.push_back(p_none());
            do_barrier(warps[i], 2'd1, 2'd2);
            e = sb.pop_front(); checks++;
            if (obs() !== e) begin errors++; $display("FAIL bar%0d_pulse got=%h want=%h", i, obs(), e); end
            checks++;
            if (stalled_warps !== stall[i]) begin errors++; $display("FAIL bar%0d_stalled got=%b want=%b", i, stalled_warps, stall[i]); end
        end
        do_barrier(2'd1, 2'd1, 2'd2);
        checks++;
        if (stalled_warps !== 4'b0000) begin errors++; $display("FAIL bar_release2 got=%b want=0000", stalled_warps); end
        do_barrier(2'd2, 2'd2, 2'd0);
        checks++;
        if (stalled_warps !== 4'b0000) begin errors++; $display("FAIL bar_size1 got=%b want=0000", stalled_warps); end
    endtask

    task automatic test_overflow();
        logic [31:0] bpc  [5] = '{32'h304, 32'h0, 32'h300, 32'h0, 32'h0};
        logic [3:0]  tm   [5] = '{4'b0010, 4'b0011, 4'b1100, 4'b1111, 4'b1111};
        logic        isbr [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        do_tmc(2'd3, 4'hF);
        do_split(2'd3, 1'b1, 4'b0011, 4'b1100, 32'h300);
        do_split(2'd3, 1'b1, 4'b0001, 4'b0010, 32'h304);
        checks++;
        if (thread_masks[15:12] !== 4'b0001) begin errors++; $display("FAIL ovf_fill_tmask got=%b want=0001", thread_masks[15:12]); end
        sb.push_back(p_err());
        do_split(2'd3, 1'b1, 4'b1000, 4'b0001, 32'h308);
        e = sb.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL ovf_split_err got=%h want=%h", obs(), e); end
        checks++;
        if (thread_masks[15:12] !== 4'b0001) begin errors++; $display("FAIL ovf_tmask got=%b want=0001", thread_masks[15:12]); end
        for (int i = 0; i < 5; i++) begin
            if (i == 4) sb.push_back(p_err());
            else if (isbr[i]) sb.push_back(p_br(2'd3, bpc[i]));
            else sb.push_back(p_none());
            do_join(2'd3);
            e = sb.pop_front(); checks++;
            if (obs() !== e) begin errors++; $display("FAIL ovf_join%0d_pulse got=%h want=%h", i, obs(), e); end
            checks++;
            if (thread_masks[15:12] !== tm[i]) begin errors++; $display("FAIL ovf_join%0d_tmask got=%b want=%b", i, thread_masks[15:12], tm[i]); end
        end
    endtask

    task automatic test_back_to_back();
        do_split(2'd0, 1'b1, 4'b0011, 4'b1100, 32'h400);
        @(negedge clk);
        ctl_valid = 1; ctl_wid = 2'd1; tmc_valid = 1; tmc_tmask = 4'b0111;
        join_valid = 1; join_wid = 2'd0;
        #1;
        checks++;
        if (join_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_blocked got=%b want=0", join_ready); end
        sb.push_back(p_none());
        @(posedge clk); #1;
        e = sb.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL b2b_ctl_pulse got=%h want=%h", obs(), e); end
        checks++;
        if (thread_masks[7:0] !== 8'h73) begin errors++; $display("FAIL b2b_ctl_tmask got=%h want=73", thread_masks[7:0]); end
        ctl_valid = 0; tmc_valid = 0; tmc_tmask = 0; ctl_wid = 0;
        #1;
        checks++;
        if (join_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_free got=%b want=1", join_ready); end
        sb.push_back(p_br(2'd0, 32'h400));
        @(posedge clk); #1;
        clear_inputs();
        e = sb.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL b2b_join_pulse got=%h want=%h", obs(), e); end
        checks++;
        if (thread_masks[3:0] !== 4'b1100) begin errors++; $display("FAIL b2b_join_tmask got=%b want=1100", thread_masks[3:0]); end
    endtask

    task automatic test_reset_midrun();
        do_wspawn(2'd0, 4'b1110, 32'h500);
        do_split(2'd1, 1'b1, 4'b0001, 4'b0000, 32'h600);
        do_barrier(2'd2, 2'd3, 2'd3);
        checks++;
        if (stalled_warps !== 4'b0100 || active_warps !== 4'b1111) begin
            errors++; $display("FAIL pre_reset got stalled=%b active=%b want 0100/1111", stalled_warps, active_warps);
        end
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        checks++;
        if (active_warps !== 4'b0001) begin errors++; $display("FAIL midreset_active got=%b want=0001", active_warps); end
        checks++;
        if (thread_masks !== 16'h0001) begin errors++; $display("FAIL midreset_tmask got=%h want=0001", thread_masks); end
        checks++;
        if (stalled_warps !== 4'b0000) begin errors++; $display("FAIL midreset_stalled got=%b want=0000", stalled_warps); end
        @(negedge clk);
        reset = 1'b1;
        sb.push_back(p_err());
        do_join(2'd1);
        e = sb.pop_front(); checks++;
        if (obs() !== e) begin errors++; $display("FAIL midreset_stack_empty got=%h want=%h", obs(), e); end
        checks++;
        if (thread_masks !== 16'h0001) begin errors++; $display("FAIL midreset_join_tmask got=%h want=0001", thread_masks); end
    endtask

    initial begin
        test_reset();
        test_wspawn();
        test_split();
        test_barrier();
        test_overflow();
        test_back_to_back();
        test_reset_midrun();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vx_warp_ctl_handler.md
Name: vx_warp_ctl_handler

Overview:
- Consumer end of the warp-control interface driven by the GPU execute unit.
- Owns per-warp scheduling state: active-warp mask, per-warp thread masks, barrier stall tracking and per-warp IPDOM reconvergence stacks.
- Its registered outputs feed the warp scheduler.
- A separate join port, from the issue stage, pops the IPDOM stack.

Parameters:
NUM_WARPS, 4, number of warps; NW_BITS = clog2(NUM_WARPS)
NUM_THREADS, 4, threads per warp
NUM_BARRIERS, 4, barrier ids; NB_BITS = clog2(NUM_BARRIERS)
IPDOM_DEPTH, 4, IPDOM stack entries per warp

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
ctl_valid  in  1  warp-control request strobe; one-cycle pulse, no backpressure
ctl_wid  in  NW_BITS  target warp
tmc_valid  in  1  thread-mask change
tmc_tmask  in  NUM_THREADS  new thread mask
wspawn_valid  in  1  warp spawn
wspawn_wmask  in  NUM_WARPS  warps to spawn
wspawn_pc  in  32  spawn start PC
split_valid  in  1  divergent branch
split_diverged  in  1  both paths non-empty
split_then_tmask  in  NUM_THREADS  taken threads
split_else_tmask  in  NUM_THREADS  not-taken threads
split_pc  in  32  else-path PC
barrier_valid  in  1  barrier arrival
barrier_id  in  NB_BITS  barrier id
barrier_size_m1  in  NW_BITS  participating warps minus one
join_valid  in  1  join request
join_wid  in  NW_BITS  warp executing join
join_ready  out  1  join accepted this cycle
active_warps  out  NUM_WARPS  warps enabled
stalled_warps  out  NUM_WARPS  warps blocked at a barrier
thread_masks  out  NUM_WARPS*NUM_THREADS  per-warp tmask; warp i at [i*NUM_THREADS +: NUM_THREADS]
wspawn_out_valid  out  1  spawn PC redirect pulse
wspawn_out_wmask  out  NUM_WARPS  warps to redirect
wspawn_out_pc  out  32  redirect PC
branch_valid  out  1  join-taken redirect pulse
branch_wid  out  NW_BITS  warp to redirect
branch_pc  out  32  redirect PC
ipdom_err  out  1  one-cycle pulse on stack overflow or underflow

Behaviour:
- Reset (asynchronous, on reset low):
  - active_warps = 1 (warp 0 only); thread_masks warp 0 = 1 (thread 0), all other warps 0.
  - stalled_warps = 0; all stacks empty; barrier counters 0; all pulse outputs 0.
- All state and outputs are registered; a request taken at edge N is visible after edge N.
- ctl_valid with multiple sub-valids: apply only the highest priority, order tmc > wspawn > split > barrier. ctl_valid with none set: no-op.
- join_ready = !ctl_valid. Control requests win; join_valid must hold until join_ready.
- TMC: tmask[wid] <= tmc_tmask. If tmc_tmask == 0, clear active_warps[wid].
- WSPAWN:
  - For each i with wspawn_wmask[i]=1 and i != ctl_wid: set active_warps[i] and tmask[i] = 1.
  - Pulse wspawn_out_valid with that mask (ctl_wid bit cleared) and wspawn_pc.
  - An all-zero resulting mask produces no pulse.
- SPLIT, diverged, stack needs 2 free entries:
  - Push {fallthrough=1, tmask[wid]}, then push {fallthrough=0, else_tmask, split_pc}.
  - tmask[wid] <= then_tmask.
- SPLIT, not diverged, needs 1 free entry: push {fallthrough=1, tmask[wid]}; tmask unchanged.
- SPLIT, insufficient space: no push, tmask unchanged, ipdom_err pulse.
- JOIN, accepted: pop the top entry of stack[join_wid].
  - fallthrough=1: tmask <= entry tmask; no branch.
  - fallthrough=0: tmask <= entry tmask; pulse branch_valid with join_wid and entry pc.
- JOIN on an empty stack: no state change, ipdom_err pulse.
- Stack pointer is 0..IPDOM_DEPTH per warp; no wrap-around.
- BARRIER:
  - If count[id] == size_m1: clear stalled_warps for every warp in waitmask[id]; clear waitmask[id] and count[id]. The arriving warp is not stalled.
  - Otherwise: count[id]++, set waitmask[id][wid] and stalled_warps[wid].
  - size_m1 == 0 releases immediately.
  - A stalled warp sending a barrier is a protocol violation; behaviour is undefined.
- TMC and split on an inactive warp still update state; the handler does not gate on active_warps.

Test Plan:
- Reset low mid-run with warps 1-3 active and stack depth 2 -> active_warps=4'b0001, thread_masks=16'h0001, stacks empty, stalled_warps=0 immediately.
- wspawn wid=0, wmask=4'b1111, pc=0x80000100 -> next cycle active_warps=4'b1111, tmask[1..3]=4'b0001, wspawn_out_valid with wmask=4'b1110 and pc 0x80000100. Then tmc wid=2, tmask=0 -> active_warps=4'b1011.
- Warp 0 tmask=4'hF, split diverged then=4'b0011, else=4'b1100, pc=0x200 -> tmask[0]=4'b0011. First join -> tmask=4'b1100, branch_valid wid 0 pc 0x200. Second join -> tmask=4'hF, no branch.
- Barrier id 1, size_m1=2, arrivals from warps 0,1,2 on separate cycles -> stalled_warps goes 0001, then 0011, then 0000 after warp 2; count[1] returns to 0.
- IPDOM_DEPTH=4: two diverged splits on warp 3 then a third -> third causes ipdom_err and tmask unchanged. Five joins -> the fifth causes ipdom_err.
- ctl_valid and join_valid in the same cycle -> join_ready=0, ctl applied; join accepted the next cycle with the expected pop.
